// File: rtl/scan_sequencer_if.sv
// ----------------------------------------------------------------------------
// scan_sequencer_if
//   Bundles the request/response handshake of the scan sequencer together with
//   the chain-head scan signals, so the sequencer takes one bus port.
//
//   Handshake: the front end raises `start` with `active_select`/`inputs` valid
//   in the same cycle. The sequencer looks at `start` only while idle. A valid
//   request is accepted on that edge and `busy` rises the next cycle. The
//   sequencer then ignores `start` until it has returned to idle.
//   `done` pulses for one cycle when `outputs` is valid, and `busy` drops in
//   the same cycle. A request with an out-of-range select is refused with a
//   one-cycle `sel_err` pulse, and `busy` and `outputs` are left unchanged.
//
//   Signals
//     start, active_select[8:0], inputs[NUM_IOS-1:0]   request (master -> slave)
//     outputs[NUM_IOS-1:0], busy, done, sel_err        response (slave -> master)
//     scan_clk_out, scan_data_out, scan_select,
//     scan_latch_en                                    chain head (slave -> chain)
//     scan_data_in                                     chain tail (chain -> slave)
//     dbg_state[2:0]                                   sequencer FSM state, debug only
// ----------------------------------------------------------------------------
interface scan_sequencer_if #(
    parameter int NUM_IOS = 8
);
    logic               start;
    logic [8:0]         active_select;
    logic [NUM_IOS-1:0] inputs;
    logic [NUM_IOS-1:0] outputs;
    logic               busy;
    logic               done;
    logic               sel_err;
    logic               scan_clk_out;
    logic               scan_data_out;
    logic               scan_select;
    logic               scan_latch_en;
    logic               scan_data_in;
    logic [2:0]         dbg_state;

    // Environment side: the pad/LA front end together with the chain itself.
    modport master (
        output start, active_select, inputs, scan_data_in,
        input  outputs, busy, done, sel_err,
        input  scan_clk_out, scan_data_out, scan_select, scan_latch_en,
        input  dbg_state
    );

    // Sequencer side.
    modport slave (
        input  start, active_select, inputs, scan_data_in,
        output outputs, busy, done, sel_err,
        output scan_clk_out, scan_data_out, scan_select, scan_latch_en,
        output dbg_state
    );
endinterface

// File: rtl/scan_sequencer.sv
// ----------------------------------------------------------------------------
// scan_sequencer
//   Runs one complete transaction on the daisy-chained design scan chain:
//     1. Shift the input byte into the selected design's slot.
//     2. Latch the slot contents onto the design inputs.
//     3. Capture every design's outputs into the chain.
//     4. Shift the whole chain back and extract the selected design's bits.
//
//   Parameters
//     NUM_DESIGNS  designs on the chain (valid select 0..NUM_DESIGNS-1)
//     NUM_IOS      I/O bits per design; each chain slot is 2*NUM_IOS bits
//     CLK_DIV      clk cycles per scan-clock half period (>= 1)
//
//   Ports
//     clk    system clock; all logic runs on the rising edge
//     reset  synchronous, active-high; aborts any transaction in flight
//     bus    scan_sequencer_if.slave: request/response handshake, chain-head
//            scan signals and a debug copy of the FSM state
//
//   One scan pulse lasts 2*CLK_DIV cycles: CLK_DIV cycles low, then CLK_DIV
//   cycles high. Serial data changes only on the first low cycle of a pulse.
//   Returning data is sampled on the last high cycle of a pulse.
//   Every output is a register. Output next-values are derived from the
//   next-state values, so each output lines up with the state register.
// ----------------------------------------------------------------------------
module scan_sequencer #(
    parameter int NUM_DESIGNS = 250,
    parameter int NUM_IOS     = 8,
    parameter int CLK_DIV     = 1
) (
    input  logic            clk,
    input  logic            reset,
    scan_sequencer_if.slave bus
);
    localparam int SLOT = 2 * NUM_IOS;
    localparam int L    = NUM_DESIGNS * SLOT;
    localparam int CW   = $clog2(L + 1);
    localparam int DW   = $clog2(2 * CLK_DIV + 1);

    localparam logic [CW-1:0] LAST_PULSE = CW'(L - 1);
    localparam logic [DW-1:0] LAST_DIV   = DW'(2 * CLK_DIV - 1);
    localparam logic [DW-1:0] HALF       = DW'(CLK_DIV);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SHIFT_IN  = 3'd1,
        ST_LATCH     = 3'd2,
        ST_CAPTURE   = 3'd3,
        ST_SHIFT_OUT = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [DW-1:0]      div_q, div_d;        // cycle position inside a scan pulse
    logic [CW-1:0]      pulse_q, pulse_d;    // pulse index inside a shift phase
    logic [CW-1:0]      base_q, base_d;      // first pulse of the selected slot's data window
    logic [NUM_IOS-1:0] in_sr_q, in_sr_d;    // input bits still to be shifted out, MSB first
    logic [NUM_IOS-1:0] out_sr_q, out_sr_d;  // bits collected from the chain tail
    logic [NUM_IOS-1:0] outputs_q, outputs_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               sel_err_q, sel_err_d;
    logic               scan_clk_q, scan_clk_d;
    logic               scan_data_q, scan_data_d;
    logic               scan_select_q, scan_select_d;
    logic               scan_latch_q, scan_latch_d;

    logic               last_div;
    logic               sel_ok;
    logic [CW-1:0]      sel_base;

    // The selected design's data occupies NUM_IOS consecutive pulses,
    // starting at base, in both shift phases.
    function automatic logic in_window(input logic [CW-1:0] p, input logic [CW-1:0] b);
        logic [CW-1:0] off;
        off = p - b;
        return (p >= b) && (off < CW'(NUM_IOS));
    endfunction

    assign sel_ok   = 32'(bus.active_select) < 32'(NUM_DESIGNS);
    // Designs farther from the chain head are reached by earlier pulses.
    assign sel_base = CW'((32'(NUM_DESIGNS) - 32'd1 - 32'(bus.active_select)) * 32'(SLOT));

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        pulse_d   = pulse_q;
        base_d    = base_q;
        in_sr_d   = in_sr_q;
        out_sr_d  = out_sr_q;
        outputs_d = outputs_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        sel_err_d = 1'b0;
        last_div  = (div_q == LAST_DIV);

        // Every active phase is built from whole scan pulses.
        if (state_q inside {ST_SHIFT_IN, ST_LATCH, ST_CAPTURE, ST_SHIFT_OUT}) begin
            div_d = last_div ? '0 : div_q + DW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (sel_ok) begin
                        state_d  = ST_SHIFT_IN;
                        base_d   = sel_base;
                        in_sr_d  = bus.inputs;
                        out_sr_d = '0;
                        div_d    = '0;
                        pulse_d  = '0;
                        busy_d   = 1'b1;
                    end else begin
                        sel_err_d = 1'b1;
                    end
                end
            end
            ST_SHIFT_IN: begin
                if (last_div) begin
                    if (pulse_q == LAST_PULSE) begin
                        state_d = ST_LATCH;
                        pulse_d = '0;
                    end else begin
                        pulse_d = pulse_q + CW'(1);
                    end
                end
            end
            ST_LATCH: begin
                if (last_div) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (last_div) state_d = ST_SHIFT_OUT;
            end
            ST_SHIFT_OUT: begin
                if (last_div) begin
                    // The first sampled window bit ends up in the MSB.
                    if (in_window(pulse_q, base_q)) begin
                        out_sr_d = NUM_IOS'({out_sr_q, bus.scan_data_in});
                    end
                    if (pulse_q == LAST_PULSE) begin
                        state_d = ST_DONE;
                        pulse_d = '0;
                    end else begin
                        pulse_d = pulse_q + CW'(1);
                    end
                end
            end
            ST_DONE: begin
                // The result becomes visible all at once, never bit by bit.
                outputs_d = out_sr_q;
                done_d    = 1'b1;
                busy_d    = 1'b0;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Scan-side outputs for the cycle that the next-state values describe.
        scan_clk_d    = (state_d inside {ST_SHIFT_IN, ST_CAPTURE, ST_SHIFT_OUT}) && (div_d >= HALF);
        scan_latch_d  = (state_d == ST_LATCH) && (div_d < HALF);
        scan_select_d = (state_d == ST_CAPTURE);

        // Serial data is updated only when a new SHIFT_IN pulse begins.
        scan_data_d = scan_data_q;
        if (state_d != ST_SHIFT_IN) begin
            scan_data_d = 1'b0;
        end else if (div_d == '0) begin
            if (in_window(pulse_d, base_d)) begin
                scan_data_d = in_sr_d[NUM_IOS-1];
                in_sr_d     = in_sr_d << 1;
            end else begin
                scan_data_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            div_q         <= '0;
            pulse_q       <= '0;
            base_q        <= '0;
            in_sr_q       <= '0;
            out_sr_q      <= '0;
            outputs_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            sel_err_q     <= 1'b0;
            scan_clk_q    <= 1'b0;
            scan_data_q   <= 1'b0;
            scan_select_q <= 1'b0;
            scan_latch_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            pulse_q       <= pulse_d;
            base_q        <= base_d;
            in_sr_q       <= in_sr_d;
            out_sr_q      <= out_sr_d;
            outputs_q     <= outputs_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            sel_err_q     <= sel_err_d;
            scan_clk_q    <= scan_clk_d;
            scan_data_q   <= scan_data_d;
            scan_select_q <= scan_select_d;
            scan_latch_q  <= scan_latch_d;
        end
    end

    assign bus.outputs       = outputs_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.sel_err       = sel_err_q;
    assign bus.scan_clk_out  = scan_clk_q;
    assign bus.scan_data_out = scan_data_q;
    assign bus.scan_select   = scan_select_q;
    assign bus.scan_latch_en = scan_latch_q;
    assign bus.dbg_state     = state_q;

endmodule
